// File: rtl/encoder42_q.sv
// Queued 4-to-2 priority encoder: sticky pending set of request lines, drained one
// 2-bit index per valid/ready transfer in HI_FIRST-selected priority order.

module encoder42_lane (
    input  logic req,
    input  logic pend,
    input  logic clr,
    output logic pend_nxt,
    output logic dup
);
    // A request on the edge its line is loaded re-enters pending rather than counting as a duplicate.
    assign pend_nxt = (pend & ~clr) | req;
    assign dup      = req & pend & ~clr;
endmodule

module encoder42_q #(
    parameter int HI_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] y,
    output logic       valid,
    input  logic       ready,
    output logic [3:0] pending,
    output logic       ovf
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [1:0] y_nxt, sel;
    logic [3:0] clr, pend_nxt, dup;
    logic       load, any;

    assign any   = |pending;
    assign load  = (state == EMPTY) | ready;
    assign valid = (state == FULL);

    // Later loop iterations overwrite earlier ones, so the last set bit visited wins.
    always_comb begin
        sel = 2'd0;
        if (HI_FIRST != 0) begin
            for (int k = 0; k < 4; k++)
                if (pending[k]) sel = 2'(k);
        end else begin
            for (int k = 3; k >= 0; k--)
                if (pending[k]) sel = 2'(k);
        end
    end

    always_comb begin
        state_nxt = state;
        y_nxt     = y;
        clr       = 4'b0000;
        if (load) begin
            if (any) begin
                state_nxt = FULL;
                y_nxt     = sel;
                clr[sel]  = 1'b1;
            end else begin
                state_nxt = EMPTY;
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        encoder42_lane u_lane (
            .req      (req[k]),
            .pend     (pending[k]),
            .clr      (clr[k]),
            .pend_nxt (pend_nxt[k]),
            .dup      (dup[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            y       <= 2'b00;
            pending <= 4'b0000;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            y       <= y_nxt;
            pending <= pend_nxt;
            ovf     <= ovf | (|dup);
        end
    end
endmodule

// File: tb/tb_encoder42_q.sv
// Bench for encoder42_q: directed vector table, low-first drain, reset cases and a
// randomized run checked against a scoreboard of expected transfer indices.

module tb_encoder42_q;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;
    logic [1:0] y, y_lo;
    logic       valid, valid_lo, ovf, ovf_lo;
    logic [3:0] pending, pending_lo;

    always #5 clk = ~clk;

    encoder42_q #(.HI_FIRST(1)) dut (
        .clk(clk), .rst(rst), .req(req), .y(y), .valid(valid),
        .ready(ready), .pending(pending), .ovf(ovf)
    );
    encoder42_q #(.HI_FIRST(0)) dut_lo (
        .clk(clk), .rst(rst), .req(req), .y(y_lo), .valid(valid_lo),
        .ready(ready), .pending(pending_lo), .ovf(ovf_lo)
    );

    int nchk = 0;
    int nfail = 0;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [1:0] y;
        logic       v;
        logic [3:0] p;
        logic       o;
    } vec_t;
    vec_t tbl[21];

    // reference model (HI_FIRST=1) and scoreboard
    logic [3:0] pm;
    logic       vm, om;
    logic [1:0] ym;
    logic [1:0] q[$];
    int acc[4];
    int xf[4];
    int dupcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick_hi(input logic [3:0] p);
        for (int k = 3; k >= 0; k--)
            if (p[k]) return 2'(k);
        return 2'd0;
    endfunction

    task automatic model_reset();
        pm = 4'b0000; vm = 1'b0; ym = 2'b00; om = 1'b0;
        q.delete();
    endtask

    task automatic model_step();
        logic [3:0] c;
        logic [1:0] s;
        c = 4'b0000;
        if (!vm || ready) begin
            if (pm != 4'b0000) begin
                s = pick_hi(pm);
                c[s] = 1'b1;
                ym = s;
                vm = 1'b1;
                q.push_back(s);
            end else begin
                vm = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (req[k] && pm[k] && !c[k]) dupcnt++;
            if (req[k] && !(pm[k] && !c[k])) acc[k]++;
        end
        if ((req & pm & ~c) != 4'b0000) om = 1'b1;
        pm = (pm & ~c) | req;
    endtask

    // Drive inputs, score any transfer that the coming edge completes, then advance.
    task automatic step(input logic [3:0] r, input logic rd);
        logic [1:0] e;
        req = r;
        ready = rd;
        #1;
        if (!rst && valid && ready) begin
            nchk++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL sb_underflow: got y=%0d with no expected entry", y);
            end else begin
                e = q.pop_front();
                if (y !== e) begin
                    nfail++;
                    $display("FAIL sb_y: got %0d expected %0d at %0t", y, e, $time);
                end
            end
            xf[y]++;
        end
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_y"}, y, 2'b00);
        chk({name, "_valid"}, valid, 1'b0);
        chk({name, "_pending"}, pending, 4'b0000);
        chk({name, "_ovf"}, ovf, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{4'b0100, 1'b1, 2'b00, 1'b0, 4'b0100, 1'b0};
        tbl[1]  = '{4'b0000, 1'b1, 2'b10, 1'b1, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0000, 1'b1, 2'b10, 1'b0, 4'b0000, 1'b0};
        tbl[3]  = '{4'b1011, 1'b1, 2'b10, 1'b0, 4'b1011, 1'b0};
        tbl[4]  = '{4'b0000, 1'b1, 2'b11, 1'b1, 4'b0011, 1'b0};
        tbl[5]  = '{4'b0000, 1'b1, 2'b01, 1'b1, 4'b0001, 1'b0};
        tbl[6]  = '{4'b0000, 1'b1, 2'b00, 1'b1, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0000, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0011, 1'b0, 2'b00, 1'b0, 4'b0011, 1'b0};
        tbl[9]  = '{4'b0000, 1'b0, 2'b01, 1'b1, 4'b0001, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 2'b01, 1'b1, 4'b0001, 1'b0};
        tbl[11] = '{4'b0000, 1'b0, 2'b01, 1'b1, 4'b0001, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 2'b01, 1'b1, 4'b0001, 1'b0};
        tbl[13] = '{4'b0000, 1'b0, 2'b01, 1'b1, 4'b0001, 1'b0};
        tbl[14] = '{4'b0000, 1'b1, 2'b00, 1'b1, 4'b0000, 1'b0};
        tbl[15] = '{4'b0000, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0};
        tbl[16] = '{4'b0100, 1'b1, 2'b00, 1'b0, 4'b0100, 1'b0};
        tbl[17] = '{4'b0100, 1'b1, 2'b10, 1'b1, 4'b0100, 1'b0};
        tbl[18] = '{4'b0100, 1'b0, 2'b10, 1'b1, 4'b0100, 1'b1};
        tbl[19] = '{4'b0000, 1'b1, 2'b10, 1'b1, 4'b0000, 1'b1};
        tbl[20] = '{4'b0000, 1'b1, 2'b10, 1'b0, 4'b0000, 1'b1};

        for (int k = 0; k < 4; k++) begin acc[k] = 0; xf[k] = 0; end
        dupcnt = 0;
        model_reset();

        // reset held with toggling requests
        #2;
        chk_zero("rst_init");
        for (int i = 0; i < 4; i++) begin
            step((i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b1);
            chk_zero("rst_hold");
        end
        rst = 1'b0;

        // asynchronous reset mid-cycle
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        chk("pre_async_valid", valid, 1'b1);
        chk("pre_async_y", y, 2'b10);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b0000, 1'b1);
        chk("post_rst_valid", valid, 1'b0);
        chk("post_rst_pending", pending, 4'b0000);

        // directed vector table
        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].req, tbl[i].rdy);
            chk($sformatf("tbl%0d_y", i), y, tbl[i].y);
            chk($sformatf("tbl%0d_valid", i), valid, tbl[i].v);
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].p);
            chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].o);
        end

        // low-first drain
        do_reset();
        chk("lo_rst_ovf", ovf_lo, 1'b0);
        step(4'b1011, 1'b1);
        chk("lo_pend", pending_lo, 4'b1011);
        step(4'b0000, 1'b1);
        chk("lo_y0", y_lo, 2'b00);
        chk("lo_v0", valid_lo, 1'b1);
        step(4'b0000, 1'b1);
        chk("lo_y1", y_lo, 2'b01);
        chk("lo_v1", valid_lo, 1'b1);
        step(4'b0000, 1'b1);
        chk("lo_y2", y_lo, 2'b11);
        chk("lo_v2", valid_lo, 1'b1);
        step(4'b0000, 1'b1);
        chk("lo_vend", valid_lo, 1'b0);

        // randomized stress against the model
        do_reset();
        for (int k = 0; k < 4; k++) begin acc[k] = 0; xf[k] = 0; end
        dupcnt = 0;
        for (int i = 0; i < 10000; i++) begin
            step(4'($urandom_range(0, 15) & $urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            chk("rnd_valid", valid, vm);
            chk("rnd_pending", pending, pm);
            chk("rnd_ovf", ovf, om);
        end
        for (int i = 0; i < 8; i++) step(4'b0000, 1'b1);
        chk("drain_valid", valid, 1'b0);
        chk("drain_queue", q.size(), 0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("line%0d_transfers", k), xf[k], acc[k]);
        chk("rnd_ovf_dup", ovf, (dupcnt > 0));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/encoder42_q.md
# encoder42_q

Queued 4-to-2 priority encoder: the binary-encoding counterpart of the team's 2-to-4 one-hot decoder. Captures event pulses on four request lines into a sticky pending register, then emits each pending line's 2-bit index, one per transfer, over a valid/ready output handshake. It sits between asynchronous-rate event sources (for example, interrupt or button lines) and a consumer that drives a `decoder24` or reads a line index.

## Interface
- `HI_FIRST`, default 1: priority order. 1 = highest index (bit 3) served first; 0 = lowest index (bit 0) served first.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req` input 4: request lines, sampled every rising edge. A high bit marks that line as pending. Level or pulse; multiple bits may be high at once.
- `y` output 2: encoded index of the served line. Valid only while `valid`=1.
- `valid` output 1: `y` holds an unconsumed index.
- `ready` input 1: consumer accepts `y`. A transfer occurs on an edge where `valid`=1 and `ready`=1.
- `pending` output 4: registered set of lines awaiting service. Excludes the line currently presented on `y`.
- `ovf` output 1: sticky flag. Set when a request arrives for a line that is already pending. Cleared only by `rst`.

## Operation
- Output register has two states.
  - EMPTY (`valid`=0).
  - FULL (`valid`=1).
- `load` = !`valid` | `ready`, meaning the output register is free or is being consumed this edge.
- `sel`: when `pending` != 0, `sel` is the priority-selected set bit of `pending` (per `HI_FIRST`). `clr` = one-hot of `sel` when loading, else 0.
- Each rising edge:
  - `load` and `pending` != 0: `y` <= `sel`, `valid` <= 1 (EMPTY/FULL -> FULL), `pending` <= (`pending` & ~`clr`) | `req`.
  - `load` and `pending` == 0: `valid` <= 0 (-> EMPTY), `y` holds its last value, `pending` <= `req`.
  - !`load` (FULL and `ready`=0): `y` and `valid` hold, `pending` <= `pending` | `req`.
  - `ovf` <= `ovf` | (|(`req` & `pending` & ~`clr`)).
- A `req` bit arriving on the same edge that its line is loaded into `y` is not lost. It re-enters `pending` and is served again later. It does not set `ovf`.
- A `req` bit high on several consecutive edges while pending is counted once. `ovf` is set from the second edge onward.
- Encoding: bit k maps to `y` = k (00, 01, 10, 11), i.e. the exact inverse of `decoder24`.
- No combinational path from `req` or `ready` to any output. All outputs are registered.

## Timing
- Reset values (asynchronous, immediate): `y`=2'b00, `valid`=0, `pending`=4'b0000, `ovf`=0. Reset asserted mid-transfer discards all pending requests and the presented index. After deassertion, the first edge behaves as EMPTY with `pending`=0.
- Latency: a `req` sampled at edge N appears in `pending` after edge N. If the output register is free, `valid`/`y` present it after edge N+1, so `req` to `valid` is 2 cycles minimum.
- Throughput: one index per cycle while `ready`=1 and `pending` is non-zero (back-to-back transfers, no bubble).
- `y` must remain stable from the edge that sets `valid` until the transfer edge.
- All four bits pending with `ready`=1 drain in 4 consecutive transfers in priority order, then `valid` drops on the next edge.

## Test plan
- Reset: hold `rst`=1 with `req`=4'b1111 toggling -> `y`=00, `valid`=0, `pending`=0000, `ovf`=0 throughout. Asserting `rst` asynchronously mid-cycle clears the outputs before the next edge.
- Single request: `req`=0100 for 1 cycle, `ready`=1 -> `pending`=0100 after edge 1, `y`=10 with `valid`=1 after edge 2, `valid`=0 after edge 3, `ovf`=0.
- Priority drain: `req`=1011 for 1 cycle, `ready`=1, `HI_FIRST`=1 -> `y` sequence 11, 01, 00 on consecutive cycles, then `valid`=0. With `HI_FIRST`=0 -> sequence 00, 01, 11.
- Backpressure: `req`=0011 pulse, `ready`=0 for 5 cycles -> `y`=01, `valid`=1 held stable, `pending`=0001. Then `ready`=1 -> next edge `y`=00, following edge `valid`=0.
- Same-edge re-request: while line 2 is being loaded (`pending`=0100, output free), `req`=0100 on that edge -> `y`=10 and `pending`=0100 afterward, `ovf`=0. Then `ready`=0 and `req`=0100 again -> `ovf`=1, stays 1 until `rst`.
- Random stress: 10k cycles of random `req`/`ready` -> every `req` bit that rose while its line was not pending yields exactly one transfer with the matching `y`. `ovf` matches the reference-model duplicate count > 0.
